// File: rtl/fixed_div.sv
// Sequential signed fixed-point divider (restoring radix-2, one quotient bit per cycle).
// Latency DW+1 cycles from accept to out_valid; one op in flight, result held until out_ready.
module fixed_div #(
   parameter int TOTAL_PREC = 27,
   parameter int FRAC_BITS  = 22
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [TOTAL_PREC-1:0] a,
   input  logic [TOTAL_PREC-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [TOTAL_PREC-1:0] res,
   output logic                  ovf,
   output logic                  div_zero
);

   localparam int DW = TOTAL_PREC + FRAC_BITS;
   localparam int CW = $clog2(DW);

   localparam logic [DW-1:0] POS_LIM = {{(DW-TOTAL_PREC+1){1'b0}}, {(TOTAL_PREC-1){1'b1}}};
   localparam logic [DW-1:0] NEG_LIM = POS_LIM + DW'(1);
   localparam logic [TOTAL_PREC-1:0] MAX_RES = {1'b0, {(TOTAL_PREC-1){1'b1}}};
   localparam logic [TOTAL_PREC-1:0] MIN_RES = {1'b1, {(TOTAL_PREC-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t                state;
   logic [DW-1:0]         dvd;     // shifts dividend out, quotient bits in
   logic [TOTAL_PREC-1:0] dvs;
   logic [TOTAL_PREC:0]   rem;
   logic [CW-1:0]         cnt;
   logic                  sign_q;
   logic                  sign_a;
   logic                  zero_b;

   logic [TOTAL_PREC-1:0] a_mag;
   logic [TOTAL_PREC-1:0] b_mag;
   logic [TOTAL_PREC:0]   rem_sh;
   logic [TOTAL_PREC+1:0] trial;
   logic                  trial_neg;
   logic                  q_ovf;
   logic [TOTAL_PREC-1:0] q_low;

   // Unsigned magnitudes: the most negative operand maps to 2^(TOTAL_PREC-1), still representable.
   assign a_mag = a[TOTAL_PREC-1] ? -a : a;
   assign b_mag = b[TOTAL_PREC-1] ? -b : b;

   assign rem_sh    = {rem[TOTAL_PREC-1:0], dvd[DW-1]};
   assign trial     = {1'b0, rem_sh} - {2'b00, dvs};
   assign trial_neg = trial[TOTAL_PREC+1];

   assign q_ovf = sign_q ? (dvd > NEG_LIM) : (dvd > POS_LIM);
   assign q_low = dvd[TOTAL_PREC-1:0];

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         cnt       <= '0;
         sign_q    <= 1'b0;
         sign_a    <= 1'b0;
         zero_b    <= 1'b0;
         out_valid <= 1'b0;
         res       <= '0;
         ovf       <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q <= a[TOTAL_PREC-1] ^ b[TOTAL_PREC-1];
                  sign_a <= a[TOTAL_PREC-1];
                  zero_b <= (b == '0);
                  dvd    <= {a_mag, {FRAC_BITS{1'b0}}};
                  dvs    <= b_mag;
                  rem    <= '0;
                  cnt    <= CW'(DW - 1);
                  state  <= CALC;
               end
            end
            CALC: begin
               // Runs the full DW iterations even for b==0 so latency never varies.
               rem <= trial_neg ? rem_sh : trial[TOTAL_PREC:0];
               dvd <= {dvd[DW-2:0], ~trial_neg};
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               if (zero_b) begin
                  res      <= sign_a ? MIN_RES : MAX_RES;
                  ovf      <= 1'b0;
                  div_zero <= 1'b1;
               end else if (q_ovf) begin
                  res      <= sign_q ? MIN_RES : MAX_RES;
                  ovf      <= 1'b1;
                  div_zero <= 1'b0;
               end else begin
                  res      <= sign_q ? -q_low : q_low;
                  ovf      <= 1'b0;
                  div_zero <= 1'b0;
               end
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fixed_div.md
Name: fixed_div

Overview:
- Sequential signed fixed-point divider: res = a / b, same Q format as the renderer's fixed_mult/dot datapath (TOTAL_PREC total bits, FRAC_BITS fractional bits).
- Provides the inverse of the multiply/dot path, used for the perspective divide and for normalisation after a dot product.
- Radix-2 restoring division, one quotient bit per cycle.
- Valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
- TOTAL_PREC, 27, total signed width of a, b and res.
- FRAC_BITS, 22, fractional bits of all operands and of the result.
- Derived DW = TOTAL_PREC + FRAC_BITS: dividend magnitude width and iteration count (49 at defaults).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  divider can accept operands.
- a  in  TOTAL_PREC  signed dividend.
- b  in  TOTAL_PREC  signed divisor.
- out_valid  out  1  res and flags are valid.
- out_ready  in  1  consumer accepts the result.
- res  out  TOTAL_PREC  signed quotient.
- ovf  out  1  quotient saturated because of range overflow.
- div_zero  out  1  b was zero.

Behaviour:
- Reset (rst=1 at a posedge):
  - state goes to IDLE.
  - in_ready=1, out_valid=0, res=0, ovf=0, div_zero=0.
  - Reset overrides everything, including a pending accept and an operation mid-CALC; the in-flight operation is discarded and no output is produced for it.
- States: IDLE, CALC, FIX, DONE.
- in_ready = 1 only in IDLE; it is driven combinationally from state.
- IDLE:
  - Accept occurs when in_valid & in_ready at a posedge.
  - On accept, latch: sign = a[msb]^b[msb]; sign of a; zero flag (b==0).
  - Load the dividend magnitude |a| << FRAC_BITS (DW bits) and the divisor magnitude |b| (TOTAL_PREC bits, unsigned). |-2^(TOTAL_PREC-1)| must be representable.
  - Clear the remainder, set iteration counter = DW-1, go to CALC.
- CALC:
  - Each posedge: shift {rem, dividend} left by 1 and trial-subtract the divisor.
  - If non-negative, commit the subtraction and shift in quotient bit 1; otherwise restore and shift in 0.
  - The remainder register is TOTAL_PREC+1 bits.
  - After the counter reaches 0 (DW iterations total), go to FIX.
  - When the zero flag is set, CALC still runs its DW cycles; its quotient is ignored. Latency is constant.
- FIX (one cycle); priority order:
  - div_zero: res = 2^(TOTAL_PREC-1)-1 if a >= 0, else -2^(TOTAL_PREC-1); ovf=0; div_zero=1.
  - Otherwise, overflow if the unsigned quotient magnitude q exceeds the limit:
    - positive result: limit is 2^(TOTAL_PREC-1)-1;
    - negative result: limit is 2^(TOTAL_PREC-1).
  - On overflow, saturate to the matching extreme and set ovf=1.
  - Otherwise res = sign ? -q : q (truncation toward zero), ovf=0.
  - Go to DONE with out_valid=1.
- Latency: out_valid rises DW+1 posedges after the accept edge (50 at defaults).
- DONE:
  - out_valid=1; res, ovf and div_zero are held stable while out_ready=0.
  - On a posedge with out_ready=1: out_valid=0 and go to IDLE. in_ready=1 on the following cycle; there is no same-cycle re-accept.
  - res and flags keep their last values after the handshake until the next FIX.
- Input changes on a and b outside the accept edge have no effect.
- Throughput: at most one result per DW+3 cycles.

Test Plan:
- a=4194304 (1.0), b=8388608 (2.0), out_ready=1 -> res=2097152 (0.5), ovf=0, div_zero=0; out_valid rises exactly 50 posedges after the accept edge.
- a=-12582912 (-3.0), b=6291456 (1.5) -> res=-8388608 (-2.0). Then a=4194304, b=12582912 -> res=1398101. Then a=-4194304, b=12582912 -> res=-1398101 (truncation toward zero).
- a=41943040 (10.0), b=2097152 (0.5) -> res=67108863, ovf=1. a=-41943040, b=2097152 -> res=-67108864, ovf=1.
- a=4194304, b=0 -> res=67108863, div_zero=1, ovf=0. a=-4194304, b=0 -> res=-67108864, div_zero=1. Latency is still 50 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, res and flags are stable and in_ready=0 throughout. Raise out_ready -> out_valid falls the next cycle and in_ready=1.
- Assert rst for one cycle 20 cycles after an accept -> next cycle out_valid=0, in_ready=1, res=0. A subsequent operation (4194304/8388608) completes normally with res=2097152.
